// File: rtl/alu_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : FSM encodings (ST_IDLE, ST_CALC)
//   prod_width() : product width helper (operand width + factor width)
//   DEF_PROD_W   : product width of the default configuration (6 + 4)
package alu_mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } mult_state_t;

    localparam int DEF_WIDTH    = 6;
    localparam int DEF_FACTOR_W = 4;
    localparam int DEF_PROD_W   = DEF_WIDTH + DEF_FACTOR_W;

    function automatic int prod_width(input int width, input int factor_w);
        return width + factor_w;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add step of the multiplier (purely combinational).
//   acc, a_sh, k_sh           : current accumulator, shifted multiplicand, shifted factor
//   acc_next                  : acc + (k_sh[0] ? a_sh : 0)
//   a_sh_next / k_sh_next     : a_sh << 1 / k_sh >> 1
module mult_step
    import alu_mult_pkg::*;
#(
    parameter int PROD_W   = DEF_PROD_W,
    parameter int FACTOR_W = DEF_FACTOR_W
) (
    input  logic [PROD_W-1:0]   acc,
    input  logic [PROD_W-1:0]   a_sh,
    input  logic [FACTOR_W-1:0] k_sh,
    output logic [PROD_W-1:0]   acc_next,
    output logic [PROD_W-1:0]   a_sh_next,
    output logic [FACTOR_W-1:0] k_sh_next
);

    // Sum wraps modulo 2^PROD_W; the full product always fits in PROD_W bits.
    assign acc_next  = acc + (k_sh[0] ? a_sh : '0);
    assign a_sh_next = a_sh << 1;
    assign k_sh_next = k_sh >> 1;

endmodule

// File: rtl/mod_multiplicador_seq.sv
// Sequential shift-add multiplier: F = A * K over a START/DONE handshake.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   START : request, sampled only while BUSY=0
//   A     : WIDTH-bit multiplicand (two's complement when SIGNED=1)
//   K     : FACTOR_W-bit unsigned factor
//   BUSY  : high while a multiplication is in progress
//   DONE  : one-cycle pulse, F valid in that cycle
//   F     : WIDTH+FACTOR_W product, registered, held until the next DONE
// Optional macro EARLY_EXIT_EN: finish as soon as no set factor bits remain,
// so latency becomes max(1, msb(K)+1) instead of a fixed FACTOR_W cycles.
module mod_multiplicador_seq
    import alu_mult_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int FACTOR_W = DEF_FACTOR_W,
    parameter int SIGNED   = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      START,
    input  logic [WIDTH-1:0]          A,
    input  logic [FACTOR_W-1:0]       K,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [WIDTH+FACTOR_W-1:0] F
);

    localparam int PROD_W = prod_width(WIDTH, FACTOR_W);
    localparam int CNT_W  = (FACTOR_W > 1) ? $clog2(FACTOR_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR_W - 1);

    mult_state_t         state, state_next;
    logic [PROD_W-1:0]   acc, a_sh, acc_next, a_sh_next;
    logic [FACTOR_W-1:0] k_sh, k_sh_next;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   f_r;
    logic                done_r;
    logic                load, step, fin, last_step;
    logic [PROD_W-1:0]   a_ext;

    // Operand extension to full product width.
    assign a_ext = (SIGNED != 0) ? {{FACTOR_W{A[WIDTH-1]}}, A}
                                 : {{FACTOR_W{1'b0}}, A};

    mult_step #(
        .PROD_W   (PROD_W),
        .FACTOR_W (FACTOR_W)
    ) u_step (
        .acc       (acc),
        .a_sh      (a_sh),
        .k_sh      (k_sh),
        .acc_next  (acc_next),
        .a_sh_next (a_sh_next),
        .k_sh_next (k_sh_next)
    );

`ifdef EARLY_EXIT_EN
    // Remaining factor bits all zero: further steps would add nothing.
    assign last_step = (cnt == CNT_LAST) || (k_sh_next == '0);
`else
    assign last_step = (cnt == CNT_LAST);
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last_step) begin
                    fin        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc    <= '0;
            a_sh   <= '0;
            k_sh   <= '0;
            cnt    <= '0;
            f_r    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= fin;
            if (load) begin
                a_sh <= a_ext;
                k_sh <= K;
                acc  <= '0;
                cnt  <= '0;
            end else if (step) begin
                acc  <= acc_next;
                a_sh <= a_sh_next;
                k_sh <= k_sh_next;
                cnt  <= cnt + 1'b1;
            end
            if (fin) f_r <= acc_next;
        end
    end

    assign BUSY = (state == ST_CALC);
    assign DONE = done_r;
    assign F    = f_r;

endmodule

// File: tb/tb_mod_multiplicador_seq.sv
module tb_mod_multiplicador_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START, start_u;
    logic [5:0] A, a_u;
    logic [3:0] K, k_u;
    logic       BUSY, DONE, busy_u, done_u;
    logic [9:0] F, f_u;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mod_multiplicador_seq #(.WIDTH(6), .FACTOR_W(4), .SIGNED(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .K(K),
        .BUSY(BUSY), .DONE(DONE), .F(F)
    );

    mod_multiplicador_seq #(.WIDTH(6), .FACTOR_W(4), .SIGNED(0)) dut_u (
        .CLK(CLK), .RST_N(RST_N), .START(start_u), .A(a_u), .K(k_u),
        .BUSY(busy_u), .DONE(done_u), .F(f_u)
    );

    function automatic int exp_lat(input logic [3:0] k);
`ifdef EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < 4; i++) if (k[i]) n = i + 1;
        return n;
`else
        return 4;
`endif
    endfunction

    // Called at #1 after an edge; returns at #1 after the DONE edge.
    task automatic run_op(input logic [5:0] a, input logic [3:0] k,
                          input logic [9:0] exp_f, input string nm);
        int edges = 0;
        int busy  = 0;
        A = a; K = k; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        while (DONE !== 1'b1 && edges < 40) begin
            if (BUSY === 1'b1) busy++;
            @(posedge CLK); #1;
            edges++;
        end
        checks++;
        if (DONE !== 1'b1 || edges != exp_lat(k)) begin
            failures++;
            $display("FAIL %s latency: got %0d edges (done=%b), want %0d", nm, edges, DONE, exp_lat(k));
        end
        checks++;
        if (F !== exp_f) begin
            failures++;
            $display("FAIL %s product: got %h, want %h", nm, F, exp_f);
        end
        checks++;
        if (busy != exp_lat(k)) begin
            failures++;
            $display("FAIL %s busy cycles: got %0d, want %0d", nm, busy, exp_lat(k));
        end
    endtask

    task automatic run_op_u(input logic [5:0] a, input logic [3:0] k,
                            input logic [9:0] exp_f, input string nm);
        int edges = 0;
        a_u = a; k_u = k; start_u = 1'b1;
        @(posedge CLK); #1;
        start_u = 1'b0;
        while (done_u !== 1'b1 && edges < 40) begin
            @(posedge CLK); #1;
            edges++;
        end
        checks++;
        if (done_u !== 1'b1 || edges != exp_lat(k) || f_u !== exp_f) begin
            failures++;
            $display("FAIL %s: got f=%h edges=%0d, want f=%h edges=%0d", nm, f_u, edges, exp_f, exp_lat(k));
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b0; start_u = 1'b0;
        A = '0; K = '0; a_u = '0; k_u = '0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || F !== 10'h000) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b f=%h, want 0 0 000", BUSY, DONE, F);
        end
        checks++;
        if (busy_u !== 1'b0 || done_u !== 1'b0 || f_u !== 10'h000) begin
            failures++;
            $display("FAIL reset_state_u: got busy=%b done=%b f=%h, want 0 0 000", busy_u, done_u, f_u);
        end
    endtask

    task automatic test_basic();
        run_op(6'h3E, 4'd5, 10'h3F6, "neg2_x5");
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: got done=%b, want 0", DONE);
        end
        checks++;
        if (F !== 10'h3F6) begin
            failures++;
            $display("FAIL f_hold: got %h, want 3f6", F);
        end
    endtask

    task automatic test_extremes();
        run_op(6'd31, 4'd15, 10'h1D1, "p31_x15");
        @(posedge CLK); #1;
        run_op(6'h20, 4'd15, 10'h220, "n32_x15");
        @(posedge CLK); #1;
        run_op(6'h3F, 4'd0, 10'h000, "n1_x0");
        @(posedge CLK); #1;
        run_op(6'h15, 4'd1, 10'h015, "x1");
        @(posedge CLK); #1;
    endtask

    task automatic test_ignored_start();
        int edges = 1;
        A = 6'd3; K = 4'd2; START = 1'b1;
        @(posedge CLK); #1;               // e0
        START = 1'b0;
        @(posedge CLK); #1;               // e1
        A = 6'd7; K = 4'd7; START = 1'b1;
        @(posedge CLK); #1;               // e2: ignored, BUSY=1
        START = 1'b0;
        edges = 2;
        while (DONE !== 1'b1 && edges < 40) begin
            @(posedge CLK); #1;
            edges++;
        end
        checks++;
        if (DONE !== 1'b1 || F !== 10'd6 || edges != exp_lat(4'd2)) begin
            failures++;
            $display("FAIL ignored_start: got f=%0d edges=%0d, want f=6 edges=%0d", F, edges, exp_lat(4'd2));
        end
        // Nothing must have been queued by the ignored request.
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_idle: got busy=%b, want 0", BUSY);
        end
    endtask

    task automatic test_back_to_back();
        run_op(6'd9, 4'd11, 10'd99, "b2b_first");
        run_op(6'h3B, 4'd6, 10'h3E2, "b2b_second");   // -5*6 = -30
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        A = 6'd5; K = 4'd9; START = 1'b1;
        @(posedge CLK); #1;               // e0
        START = 1'b0;
        @(posedge CLK); #1;               // e1: first step
        RST_N = 1'b0;
        @(posedge CLK); #1;               // e2: reset
        RST_N = 1'b1;
        checks++;
        if (BUSY !== 1'b0 || F !== 10'h000 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: got busy=%b done=%b f=%h, want 0 0 000", BUSY, DONE, F);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", seen);
        end
        run_op(6'd5, 4'd9, 10'd45, "after_reset");
        @(posedge CLK); #1;
    endtask

    task automatic test_unsigned();
        run_op_u(6'd63, 4'd15, 10'h3B1, "unsigned_63x15");
        @(posedge CLK); #1;
        run_op_u(6'd40, 4'd3, 10'd120, "unsigned_40x3");
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        logic signed [5:0] as;
        logic [3:0] kr;
        logic [9:0] exp_f;
        int ai;
        int bad = 0;
        for (int n = 0; n < 200; n++) begin
            as = 6'($urandom_range(0, 63));
            kr = 4'($urandom_range(0, 15));
            ai = as;
            exp_f = 10'(ai * int'(kr));
            A = as; K = kr; START = 1'b1;
            @(posedge CLK); #1;
            START = 1'b0;
            for (int e = 0; e < 40 && DONE !== 1'b1; e++) begin
                @(posedge CLK); #1;
            end
            checks++;
            if (DONE !== 1'b1 || F !== exp_f) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_%0d: a=%0d k=%0d got %h, want %h", n, ai, kr, F, exp_f);
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_unsigned();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
